// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory responder.
// Holds the default geometry and timing of the memory, plus the state type
// used by the responder FSM.
// Defines no ports.

package dmem_pkg;

  localparam int DMEM_WORD_SIZE   = 16;
  localparam int DMEM_MEM_WORDS   = 256;
  localparam int DMEM_WAIT_CYCLES = 1;

  // Wait-state counter width; covers 0..15 extra busy cycles.
  localparam int DMEM_CNT_BITS    = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with one write port and a registered read.
// It is written so that synthesis maps it onto block RAM. The read register
// clears on reset; this matches a block RAM output register with a
// synchronous reset. The array contents are never cleared.
//
// Ports:
//   Clock   in   clock; all updates happen on its rising edge
//   Resetn  in   synchronous active-low reset for the read register
//   we      in   write enable
//   re      in   read enable; loads rdata from mem[addr]
//   addr    in   word address
//   wdata   in   write data
//   rdata   out  registered read data; holds until the next read

module dmem_ram #(
  parameter int WORD_SIZE = 16,
  parameter int MEM_WORDS = 256,
  parameter int ADDR_BITS = $clog2(MEM_WORDS)
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory serving the processor's memory-stage port.
// Every access holds DataWaitreq high for WAIT_CYCLES + 2 cycles. The
// request cycle and the BUSY cycles count toward this. The result then
// appears for one DONE cycle, and the Memory stage stalls until then.
//
// Optional feature, macro DMEM_MMIO_EN:
//   When it is defined, a write to the full address MMIO_ADDR loads the
//   MmioOut register instead of RAM. A read of MMIO_ADDR returns that
//   register. When it is undefined, the port, the register and the
//   MMIO_ADDR parameter are absent, and that address wraps into RAM.
//
// Ports:
//   Clock        in   clock; all state updates on its rising edge
//   Resetn       in   synchronous active-low reset
//   DataAddr     in   word address; bits above the RAM index are ignored
//   DataOut      in   write data from the initiator
//   ReadData     in   read request
//   WriteData    in   write request (wins when both requests are high)
//   DataIn       out  read data; nonzero only in DONE after a read
//   DataWaitreq  out  initiator must hold its request while this is high
//   MmioOut      out  memory-mapped output register (DMEM_MMIO_EN only)

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int WORD_SIZE   = DMEM_WORD_SIZE,
  parameter int MEM_WORDS   = DMEM_MEM_WORDS,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
`ifdef DMEM_MMIO_EN
  ,
  parameter logic [WORD_SIZE-1:0] MMIO_ADDR = WORD_SIZE'(16'h1000)
`endif
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq
`ifdef DMEM_MMIO_EN
  ,
  output logic [WORD_SIZE-1:0] MmioOut
`endif
);

  localparam int ADDR_BITS = $clog2(MEM_WORDS);

  dmem_state_t              state, state_next;
  logic [DMEM_CNT_BITS-1:0] cnt, cnt_next;
  logic [ADDR_BITS-1:0]     addr_q, addr_next;
  logic [WORD_SIZE-1:0]     wdata_q, wdata_next;
  logic                     is_write_q, is_write_next;
  logic                     is_mmio_q, is_mmio_next;
  logic                     req;
  logic                     hit_mmio;
  logic                     ram_we;
  logic                     ram_re;
  logic                     mmio_we;
  logic [WORD_SIZE-1:0]     ram_rdata;
  logic [WORD_SIZE-1:0]     mmio_rdata;

  assign req = ReadData | WriteData;

`ifdef DMEM_MMIO_EN
  logic [WORD_SIZE-1:0] mmio_q;

  // The MMIO decode uses the whole address, so an alias that only matches
  // in the low bits still goes to RAM.
  assign hit_mmio   = (DataAddr == MMIO_ADDR);
  assign mmio_rdata = mmio_q;
  assign MmioOut    = mmio_q;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      mmio_q <= '0;
    end else if (mmio_we) begin
      mmio_q <= wdata_q;
    end
  end
`else
  logic unused_addr_bits;

  // Without MMIO the upper address bits have no meaning and simply wrap.
  assign hit_mmio         = 1'b0;
  assign mmio_rdata       = '0;
  assign unused_addr_bits = ^{DataAddr[WORD_SIZE-1:ADDR_BITS], mmio_we};
`endif

  // State register, plus the request captured at acceptance. The captured
  // address and data keep BUSY immune to the initiator changing its bus.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      is_mmio_q  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      addr_q     <= addr_next;
      wdata_q    <= wdata_next;
      is_write_q <= is_write_next;
      is_mmio_q  <= is_mmio_next;
    end
  end

  // Next-state logic and handshake. The RAM and MMIO strobes are gated by
  // Resetn, so a reset on the commit edge discards the pending write.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    addr_next     = addr_q;
    wdata_next    = wdata_q;
    is_write_next = is_write_q;
    is_mmio_next  = is_mmio_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    mmio_we       = 1'b0;
    DataWaitreq   = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          DataWaitreq   = 1'b1;
          addr_next     = DataAddr[ADDR_BITS-1:0];
          wdata_next    = DataOut;
          is_write_next = WriteData;
          is_mmio_next  = hit_mmio;
          cnt_next      = DMEM_CNT_BITS'(WAIT_CYCLES);
          state_next    = BUSY;
        end
      end

      BUSY: begin
        DataWaitreq = 1'b1;
        if (!req) begin
          state_next = IDLE;
        end else if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = DONE;
          if (is_write_q) begin
            ram_we  = Resetn & ~is_mmio_q;
            mmio_we = Resetn & is_mmio_q;
          end else begin
            ram_re  = Resetn & ~is_mmio_q;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read data is shown only for the single DONE cycle of a read.
  always_comb begin
    DataIn = '0;
    if (state == DONE && !is_write_q) begin
      DataIn = is_mmio_q ? mmio_rdata : ram_rdata;
    end
  end

  dmem_ram #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_WORDS (MEM_WORDS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .Clock  (Clock),
    .Resetn (Resetn),
    .we     (ram_we),
    .re     (ram_re),
    .addr   (addr_q),
    .wdata  (wdata_q),
    .rdata  (ram_rdata)
  );

endmodule
